dm_arbiter: RTL and testbench
=============================

// Module: dm_arbiter
// PURPOSE
//  Shares one single-port, word-organised data memory between two requesters: core (load/store unit) and dbg (program loader/debug).
//  Round-robin grant; byte/half lane selection; sign/zero extension on loads; read-modify-write for sub-word stores.
//  Sits between the datapath/debug ports and the synchronous data memory macro (1-cycle read latency).
// PARAMETERS
//  AW     10   memory word-address width (depth 2**AW words)
//  DW     32   data width (fixed 32; lanes are bytes)
// PORTS
//  clk          in   1   single clock; all logic on posedge
//  rst_n        in   1   synchronous, active-low reset
//  core_req     in   1   core request; held with fields stable until core_gnt
//  core_we      in   1   1=store, 0=load
//  core_ctrl    in   3   000 LB, 001 LH, 010 LW/SW, 100 LBU, 101 LHU
//  core_addr    in   32  byte address
//  core_wdata   in   32  store data (low byte/half used for sub-word)
//  core_gnt     out  1   request accepted this cycle
//  core_rvalid  out  1   response (load data or store ack) this cycle
//  core_rdata   out  32  extended load data; 0 for stores
//  dbg_*        --   --  identical set: dbg_req/we/ctrl/addr/wdata/gnt/rvalid/rdata
//  err          out  1   misaligned access flag, valid with rvalid (see CONFIGURATION)
//  mem_en       out  1   memory access strobe
//  mem_we       out  1   memory write strobe (qualified by mem_en)
//  mem_addr     out  AW  word address = addr[AW+1:2]
//  mem_wdata    out  32  full word to write
//  mem_rdata    in   32  word read, valid the cycle after mem_en & !mem_we
// BEHAVIOUR
//  Reset: state=IDLE, last_grant=DBG; all gnt/rvalid/err/mem_en/mem_we=0, rdata=0, mem_addr/mem_wdata=0.
//  FSM: IDLE, LOAD, RMW, WACK. Requests accepted only in IDLE; max one request per 2 cycles.
//  IDLE: one requester -> grant it; both -> grant the one not in last_grant (core wins first after reset).
//   Accept cycle N: gnt=1, latch we/ctrl/lane/wdata/owner, update last_grant.
//   Load -> mem_en=1 read at N, go LOAD. Word store -> mem_en=mem_we=1 at N, go WACK.
//   Sub-word store -> mem_en=1 read at N, go RMW.
//  LOAD (N+1): owner rvalid=1, rdata=extend(lane of mem_rdata); -> IDLE.
//  RMW  (N+1): mem_en=mem_we=1, mem_wdata=mem_rdata with selected lane replaced; owner rvalid=1; -> IDLE.
//  WACK (N+1): owner rvalid=1, rdata=0; -> IDLE.
//  Every accepted request gets exactly one rvalid at N+1, on the owner's port only; rvalid/rdata decoded from state (not registered).
//  Lanes: byte lane=addr[1:0] (bits 8*k+7:8*k); half lane=addr[1] (bits 16*k+15:16*k).
//  Extension: LB/LH sign-extend from lane MSB; LBU/LHU zero-extend.
//  ctrl decode: stores with 100/101 act as 000/001; codes 011,110,111 act as word.
//  Reset mid-operation takes precedence: no RMW write, no rvalid, in-flight request dropped.
//  Requester deasserting req before gnt: legal, nothing recorded.
// CONFIGURATION
//  DM_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 is granted,
//   no memory access issued, -> WACK; rvalid=1, err=1, rdata=0 at N+1.
//  Not defined: low address bits ignored (half aligns to addr[1], word to addr[1:0]=0); err tied 0.
// STRUCTURE
//  dm_pkg: ctrl localparams (DM_LB, DM_LH, DM_W, DM_LBU, DM_LHU), state enum, owner enum.
//  Sub-module dm_lane_align (combinational): load extension and store lane merge; instantiated once.
// TESTING
//  Core SW 0xDEADBEEF @0x10, then LW @0x10 -> mem_we at N, ack N+1; LW rdata=0xDEADBEEF.
//  Word 0x11223380 @0x20: LB @0x20 -> 0xFFFFFF80; LBU @0x20 -> 0x00000080; LH @0x22 -> 0x00001122.
//  SB 0xAB @0x23 over 0x11223344 -> read then write 0xAB223344; later LW returns 0xAB223344.
//  core_req and dbg_req held together 4 requests -> grants core,dbg,core,dbg; each rvalid on owner only.
//  LH @0x21: with DM_MISALIGN_TRAP_EN -> err=1, rdata=0, no mem_en; without -> reads half at 0x20.
//  rst_n low during RMW cycle -> mem_we=0, no rvalid; memory word unchanged; next cycle IDLE.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory arbiter: access codes, FSM states,
// requester identities and the access-size decode helper.
package dm_pkg;

  localparam logic [2:0] DM_LB  = 3'b000;
  localparam logic [2:0] DM_LH  = 3'b001;
  localparam logic [2:0] DM_W   = 3'b010;
  localparam logic [2:0] DM_LBU = 3'b100;
  localparam logic [2:0] DM_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RMW  = 2'd2,
    ST_WACK = 2'd3
  } dm_state_e;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_DBG  = 1'b1
  } dm_owner_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } dm_size_e;

  // Codes 011/110/111 fall into word; 100/101 share byte/half with 000/001.
  function automatic dm_size_e dm_size(input logic [2:0] ctrl);
    if (ctrl[1])      return SZ_W;
    else if (ctrl[0]) return SZ_H;
    else              return SZ_B;
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Combinational lane logic: extracts and extends a load lane, and merges a
// sub-word store into the word read back from memory.
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [31:0] rword_i,
  input  dm_size_e    size_i,
  input  logic [1:0]  lane_i,
  input  logic        uns_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rword_i[7:0];
    case (lane_i)
      2'd0: byte_sel = rword_i[7:0];
      2'd1: byte_sel = rword_i[15:8];
      2'd2: byte_sel = rword_i[23:16];
      2'd3: byte_sel = rword_i[31:24];
      default: byte_sel = rword_i[7:0];
    endcase
    half_sel = lane_i[1] ? rword_i[31:16] : rword_i[15:0];
  end

  always_comb begin
    load_o = rword_i;
    case (size_i)
      SZ_B: load_o = uns_i ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_H: load_o = uns_i ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_o = rword_i;
    endcase
  end

  always_comb begin
    merge_o = rword_i;
    case (size_i)
      SZ_B: begin
        case (lane_i)
          2'd0: merge_o[7:0]   = wdata_i[7:0];
          2'd1: merge_o[15:8]  = wdata_i[7:0];
          2'd2: merge_o[23:16] = wdata_i[7:0];
          2'd3: merge_o[31:24] = wdata_i[7:0];
          default: merge_o = rword_i;
        endcase
      end
      SZ_H: begin
        if (lane_i[1]) merge_o[31:16] = wdata_i[15:0];
        else           merge_o[15:0]  = wdata_i[15:0];
      end
      default: merge_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between core and dbg.
// Define DM_MISALIGN_TRAP_EN to trap misaligned half/word accesses with err.
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [2:0]    core_ctrl,
  input  logic [31:0]   core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_gnt,
  output logic          core_rvalid,
  output logic [DW-1:0] core_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [2:0]    dbg_ctrl,
  input  logic [31:0]   dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic          err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    fsm_state
);

  // Handshake: a requester holds req with stable fields until gnt is seen high
  // in a cycle; that cycle is the accept. Exactly one rvalid follows on the
  // next cycle, on the owner's port only. There is no backpressure on rvalid.

  dm_state_e state_q, state_d;
  dm_owner_e last_q, own_q;
  logic      we_q, uns_q, err_q;
  dm_size_e  size_q;
  logic [1:0]    lane_q;
  logic [AW-1:0] waddr_q;
  logic [DW-1:0] wdata_q;

  logic          any_req, sel_dbg, accept, mis;
  logic          r_we, r_uns;
  logic [2:0]    r_ctrl;
  logic [31:0]   r_addr;
  logic [DW-1:0] r_wdata;
  dm_size_e      r_size;
  logic [1:0]    r_lane;

  logic          gnt, rv;
  logic [DW-1:0] rd;
  logic [DW-1:0] load_data, merge_data;

  logic unused_addr_hi;
  assign unused_addr_hi = ^{core_addr[31:AW+2], dbg_addr[31:AW+2]};

  // Contention goes to whoever was not granted last; dbg is "last" at reset.
  assign any_req = core_req | dbg_req;
  assign sel_dbg = dbg_req & (!core_req | (last_q == OWN_CORE));
  assign accept  = rst_n & (state_q == ST_IDLE) & any_req;

  always_comb begin
    r_we    = sel_dbg ? dbg_we    : core_we;
    r_ctrl  = sel_dbg ? dbg_ctrl  : core_ctrl;
    r_addr  = sel_dbg ? dbg_addr  : core_addr;
    r_wdata = sel_dbg ? dbg_wdata : core_wdata;
    r_size  = dm_size(r_ctrl);
    r_uns   = r_ctrl[2];
    r_lane  = 2'b00;
    case (r_size)
      SZ_B:    r_lane = r_addr[1:0];
      SZ_H:    r_lane = {r_addr[1], 1'b0};
      default: r_lane = 2'b00;
    endcase
`ifdef DM_MISALIGN_TRAP_EN
    mis = ((r_size == SZ_H) & r_addr[0]) | ((r_size == SZ_W) & (r_addr[1:0] != 2'b00));
`else
    mis = 1'b0;
`endif
  end

  dm_lane_align u_lane_align (
    .rword_i (mem_rdata),
    .size_i  (size_q),
    .lane_i  (lane_q),
    .uns_i   (uns_q),
    .wdata_i (wdata_q),
    .load_o  (load_data),
    .merge_o (merge_data)
  );

  // Outputs are decoded from state; an asserted reset masks them in the same
  // cycle so an interrupted RMW never writes and never acknowledges.
  always_comb begin
    state_d   = state_q;
    gnt       = 1'b0;
    rv        = 1'b0;
    rd        = '0;
    err       = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rst_n) begin
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            gnt = 1'b1;
            if (mis) begin
              state_d = ST_WACK;
            end else if (!r_we) begin
              mem_en   = 1'b1;
              mem_addr = r_addr[AW+1:2];
              state_d  = ST_LOAD;
            end else if (r_size == SZ_W) begin
              mem_en    = 1'b1;
              mem_we    = 1'b1;
              mem_addr  = r_addr[AW+1:2];
              mem_wdata = r_wdata;
              state_d   = ST_WACK;
            end else begin
              mem_en   = 1'b1;
              mem_addr = r_addr[AW+1:2];
              state_d  = ST_RMW;
            end
          end
        end
        ST_LOAD: begin
          rv      = 1'b1;
          rd      = load_data;
          state_d = ST_IDLE;
        end
        ST_RMW: begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = waddr_q;
          mem_wdata = merge_data;
          rv        = 1'b1;
          state_d   = ST_IDLE;
        end
        ST_WACK: begin
          rv      = 1'b1;
          err     = err_q;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign core_gnt    = gnt & !sel_dbg;
  assign dbg_gnt     = gnt & sel_dbg;
  assign core_rvalid = rv & (own_q == OWN_CORE);
  assign dbg_rvalid  = rv & (own_q == OWN_DBG);
  assign core_rdata  = (own_q == OWN_CORE) ? rd : '0;
  assign dbg_rdata   = (own_q == OWN_DBG)  ? rd : '0;
  assign fsm_state   = state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= OWN_DBG;
      own_q   <= OWN_CORE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SZ_W;
      lane_q  <= 2'b00;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        own_q   <= sel_dbg ? OWN_DBG : OWN_CORE;
        last_q  <= sel_dbg ? OWN_DBG : OWN_CORE;
        we_q    <= r_we;
        uns_q   <= r_uns;
        err_q   <= mis;
        size_q  <= r_size;
        lane_q  <= r_lane;
        waddr_q <= r_addr[AW+1:2];
        wdata_q <= r_wdata;
      end
    end
  end

  logic unused_we;
  assign unused_we = we_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural 1-cycle-latency memory.
// Misaligned-access expectations follow DM_MISALIGN_TRAP_EN.
module tb_dm_arbiter;
  import dm_pkg::*;

  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req, core_we, dbg_req, dbg_we;
  logic [2:0]  core_ctrl, dbg_ctrl;
  logic [31:0] core_addr, core_wdata, dbg_addr, dbg_wdata;
  logic        core_gnt, core_rvalid, dbg_gnt, dbg_rvalid;
  logic [31:0] core_rdata, dbg_rdata;
  logic        err, mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [1:0]  fsm_state;

  logic [31:0] mem [0:(1<<AW)-1];
  logic [31:0] exp_q[$];
  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  dm_arbiter #(.AW(AW), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_ctrl(core_ctrl),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_gnt(core_gnt),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_ctrl(dbg_ctrl),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .err(err), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .fsm_state(fsm_state)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  // Called just after a posedge with the DUT idle; returns just after a posedge.
  task automatic do_req(input string tag, input logic is_dbg, input logic we,
                        input logic [2:0] ctrl, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic exp_en, input logic exp_we,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input logic exp_rmw, input logic [31:0] exp_rmw_wdata);
    int n;
    if (is_dbg) begin
      dbg_req = 1'b1; dbg_we = we; dbg_ctrl = ctrl; dbg_addr = addr; dbg_wdata = wdata;
    end else begin
      core_req = 1'b1; core_we = we; core_ctrl = ctrl; core_addr = addr; core_wdata = wdata;
    end
    @(negedge clk);
    n = 0;
    while (!(is_dbg ? dbg_gnt : core_gnt) && n < 8) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_gnt"}, {31'd0, is_dbg ? dbg_gnt : core_gnt}, 32'd1);
    check({tag, "_other_gnt"}, {31'd0, is_dbg ? core_gnt : dbg_gnt}, 32'd0);
    check({tag, "_mem_en"}, {31'd0, mem_en}, {31'd0, exp_en});
    check({tag, "_mem_we"}, {31'd0, mem_we}, {31'd0, exp_we});
    if (exp_en) check({tag, "_mem_addr"}, {22'd0, mem_addr}, {22'd0, addr[AW+1:2]});
    if (exp_we) check({tag, "_mem_wdata"}, mem_wdata, wdata);
    @(posedge clk);
    #1;
    core_req = 1'b0;
    dbg_req  = 1'b0;
    @(negedge clk);
    check({tag, "_rvalid"}, {31'd0, is_dbg ? dbg_rvalid : core_rvalid}, 32'd1);
    check({tag, "_other_rvalid"}, {31'd0, is_dbg ? core_rvalid : dbg_rvalid}, 32'd0);
    check({tag, "_rdata"}, is_dbg ? dbg_rdata : core_rdata, exp_rdata);
    check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    check({tag, "_rmw_we"}, {31'd0, mem_we}, {31'd0, exp_rmw});
    if (exp_rmw) check({tag, "_rmw_wdata"}, mem_wdata, exp_rmw_wdata);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_core;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'd0;
    mem_rdata = 32'd0;
    rst_n = 1'b0;
    core_req = 1'b0; core_we = 1'b0; core_ctrl = 3'd0; core_addr = 32'd0; core_wdata = 32'd0;
    dbg_req  = 1'b0; dbg_we  = 1'b0; dbg_ctrl  = 3'd0; dbg_addr  = 32'd0; dbg_wdata  = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", {30'd0, core_gnt, dbg_gnt}, 32'd0);
    check("rst_rvalid", {30'd0, core_rvalid, dbg_rvalid}, 32'd0);
    check("rst_mem", {29'd0, mem_en, mem_we, err}, 32'd0);
    check("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_rdata", core_rdata | dbg_rdata, 32'd0);
    check("rst_state", {30'd0, fsm_state}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_req("sw_10", 1'b0, 1'b1, DM_W, 32'h10, 32'hDEADBEEF, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    do_req("lw_10", 1'b0, 1'b0, DM_W, 32'h10, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
    do_req("dbg_sw_20", 1'b1, 1'b1, DM_W, 32'h20, 32'h11223380, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    do_req("lb_20", 1'b0, 1'b0, DM_LB, 32'h20, 32'h0, 1'b1, 1'b0, 32'hFFFFFF80, 1'b0, 1'b0, 32'h0);
    do_req("lbu_20", 1'b0, 1'b0, DM_LBU, 32'h20, 32'h0, 1'b1, 1'b0, 32'h00000080, 1'b0, 1'b0, 32'h0);
    do_req("lh_22", 1'b0, 1'b0, DM_LH, 32'h22, 32'h0, 1'b1, 1'b0, 32'h00001122, 1'b0, 1'b0, 32'h0);
    do_req("lhu_20", 1'b0, 1'b0, DM_LHU, 32'h20, 32'h0, 1'b1, 1'b0, 32'h00003380, 1'b0, 1'b0, 32'h0);
`ifdef DM_MISALIGN_TRAP_EN
    do_req("lh_21", 1'b0, 1'b0, DM_LH, 32'h21, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
`else
    do_req("lh_21", 1'b0, 1'b0, DM_LH, 32'h21, 32'h0, 1'b1, 1'b0, 32'h00003380, 1'b0, 1'b0, 32'h0);
`endif
    do_req("sw_20b", 1'b0, 1'b1, DM_W, 32'h20, 32'h11223344, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    do_req("sb_23", 1'b0, 1'b1, DM_LB, 32'h23, 32'h000000AB, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hAB223344);
    do_req("lw_20", 1'b0, 1'b0, DM_W, 32'h20, 32'h0, 1'b1, 1'b0, 32'hAB223344, 1'b0, 1'b0, 32'h0);
    do_req("dbg_sh_12", 1'b1, 1'b1, DM_LHU, 32'h12, 32'h0000CAFE, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hCAFEBEEF);
    do_req("dbg_lw_10", 1'b1, 1'b0, DM_W, 32'h10, 32'h0, 1'b1, 1'b0, 32'hCAFEBEEF, 1'b0, 1'b0, 32'h0);

    // Both requesters held: last grant was dbg, so core goes first.
    exp_q.push_back(32'hCAFEBEEF);
    exp_q.push_back(32'hAB223344);
    exp_q.push_back(32'hCAFEBEEF);
    exp_q.push_back(32'hAB223344);
    core_req = 1'b1; core_we = 1'b0; core_ctrl = DM_W; core_addr = 32'h10;
    dbg_req  = 1'b1; dbg_we  = 1'b0; dbg_ctrl  = DM_W; dbg_addr  = 32'h20;
    for (int k = 0; k < 4; k++) begin
      logic [31:0] exp_d;
      exp_core = (k % 2 == 0);
      @(negedge clk);
      check("arb_core_gnt", {31'd0, core_gnt}, {31'd0, exp_core});
      check("arb_dbg_gnt", {31'd0, dbg_gnt}, {31'd0, !exp_core});
      @(posedge clk);
      if (k == 3) begin
        #1;
        core_req = 1'b0;
        dbg_req  = 1'b0;
      end
      @(negedge clk);
      check("arb_core_rvalid", {31'd0, core_rvalid}, {31'd0, exp_core});
      check("arb_dbg_rvalid", {31'd0, dbg_rvalid}, {31'd0, !exp_core});
      exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXXXXXX;
      check("arb_rdata", exp_core ? core_rdata : dbg_rdata, exp_d);
      @(posedge clk);
    end
    #1;

    // Reset asserted during the RMW cycle of a byte store.
    core_req = 1'b1; core_we = 1'b1; core_ctrl = DM_LB; core_addr = 32'h10; core_wdata = 32'h55;
    @(negedge clk);
    check("rstrmw_gnt", {31'd0, core_gnt}, 32'd1);
    @(posedge clk);
    #1;
    core_req = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("rstrmw_mem_we", {31'd0, mem_we}, 32'd0);
    check("rstrmw_rvalid", {30'd0, core_rvalid, dbg_rvalid}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rstrmw_state", {30'd0, fsm_state}, 32'd0);
    check("rstrmw_mem_word", mem[4], 32'hCAFEBEEF);
    @(posedge clk);
    #1;
    do_req("lw_10_after", 1'b0, 1'b0, DM_W, 32'h10, 32'h0, 1'b1, 1'b0, 32'hCAFEBEEF, 1'b0, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
